// File: rtl/distinct_filter.sv
// rtl/distinct_filter.sv - drops hit tuples from a key stream, emits distinct keys and per-burst stats
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   clear                synchronous flush of held key, counters and FSM (output register untouched)
//   s_meta_*             input stream: tdata = key, tlast = end of burst, thit = duplicate flag
//   m_meta_*             output stream of distinct keys; thit=1 only on the empty-burst marker
//   stat_distinct/dup    distinct and duplicate counts of the last completed burst
//   stat_valid           one-cycle pulse when the stat outputs update
module distinct_filter #(
    parameter int CNT_BITS = 32,
    parameter int KEY_BITS = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                clear,

    input  logic [KEY_BITS-1:0] s_meta_tdata,
    input  logic                s_meta_tlast,
    input  logic                s_meta_thit,
    input  logic                s_meta_tvalid,
    output logic                s_meta_tready,

    output logic [KEY_BITS-1:0] m_meta_tdata,
    output logic                m_meta_tlast,
    output logic                m_meta_thit,
    output logic                m_meta_tvalid,
    input  logic                m_meta_tready,

    output logic [CNT_BITS-1:0] stat_distinct,
    output logic [CNT_BITS-1:0] stat_dup,
    output logic                stat_valid
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t              state;
    logic                ov;
    logic [KEY_BITS-1:0] o_key;
    logic                o_last;
    logic                o_hit;
    logic                hv;
    logic [KEY_BITS-1:0] hk;
    logic [CNT_BITS-1:0] cnt_dist;
    logic [CNT_BITS-1:0] cnt_dup;

    logic o_free;
    logic accept;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // The output register can take a new value when empty or draining this cycle.
    assign o_free        = !ov || m_meta_tready;
    assign s_meta_tready = aresetn && !clear && (state == RUN) && o_free;
    assign accept        = s_meta_tvalid && s_meta_tready;

    assign m_meta_tvalid = ov;
    assign m_meta_tdata  = o_key;
    assign m_meta_tlast  = o_last;
    assign m_meta_thit   = o_hit;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= RUN;
            ov            <= 1'b0;
            o_key         <= '0;
            o_last        <= 1'b0;
            o_hit         <= 1'b0;
            hv            <= 1'b0;
            hk            <= '0;
            cnt_dist      <= '0;
            cnt_dup       <= '0;
            stat_distinct <= '0;
            stat_dup      <= '0;
            stat_valid    <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            // Drain on handshake; any reload below in the same cycle wins.
            if (ov && m_meta_tready) begin
                ov <= 1'b0;
            end

            if (clear) begin
                hv       <= 1'b0;
                cnt_dist <= '0;
                cnt_dup  <= '0;
                state    <= RUN;
            end else if (state == RUN) begin
                if (accept) begin
                    if (s_meta_thit) begin
                        cnt_dup <= sat_inc(cnt_dup);
                    end else begin
                        // A key is only known not to be the burst's last once the
                        // next distinct key arrives, so it waits in H until then.
                        if (hv) begin
                            ov     <= 1'b1;
                            o_key  <= hk;
                            o_last <= 1'b0;
                            o_hit  <= 1'b0;
                        end
                        hv       <= 1'b1;
                        hk       <= s_meta_tdata;
                        cnt_dist <= sat_inc(cnt_dist);
                    end
                    if (s_meta_tlast) begin
                        state <= FLUSH;
                    end
                end
            end else if (o_free) begin
                // Emit the held key as the burst end, or a marker when the burst had no distinct key.
                ov            <= 1'b1;
                o_key         <= hv ? hk : '0;
                o_last        <= 1'b1;
                o_hit         <= !hv;
                hv            <= 1'b0;
                stat_distinct <= cnt_dist;
                stat_dup      <= cnt_dup;
                stat_valid    <= 1'b1;
                cnt_dist      <= '0;
                cnt_dup       <= '0;
                state         <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_distinct_filter.sv
// tb/tb_distinct_filter.sv - self-checking bench for distinct_filter
module tb_distinct_filter;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] s_key = '0;
    logic        s_last = 1'b0;
    logic        s_hit = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_key;
    logic        m_last;
    logic        m_hit;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] stat_distinct;
    logic [31:0] stat_dup;
    logic        stat_valid;

    int n_checks = 0;
    int n_fail = 0;

    logic [33:0] outq[$];
    int          pulses = 0;
    logic [31:0] cap_dist = '0;
    logic [31:0] cap_dup = '0;

    always #5 aclk = ~aclk;

    distinct_filter #(.CNT_BITS(32), .KEY_BITS(32)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .clear         (clear),
        .s_meta_tdata  (s_key),
        .s_meta_tlast  (s_last),
        .s_meta_thit   (s_hit),
        .s_meta_tvalid (s_valid),
        .s_meta_tready (s_ready),
        .m_meta_tdata  (m_key),
        .m_meta_tlast  (m_last),
        .m_meta_thit   (m_hit),
        .m_meta_tvalid (m_valid),
        .m_meta_tready (m_ready),
        .stat_distinct (stat_distinct),
        .stat_dup      (stat_dup),
        .stat_valid    (stat_valid)
    );

    // Inputs change only at negedge, so values seen here hold through the next posedge.
    always @(negedge aclk) begin
        #2;
        if (aresetn && m_valid && m_ready) outq.push_back({m_key, m_last, m_hit});
        if (stat_valid) begin
            pulses   = pulses + 1;
            cap_dist = stat_distinct;
            cap_dup  = stat_dup;
        end
    end

    typedef struct {
        int               n_in;
        logic [3:0][31:0] in_key;
        logic [3:0]       in_hit;
        int               n_out;
        logic [3:0][31:0] out_key;
        logic [3:0]       out_last;
        logic [3:0]       out_hit;
        int               exp_dist;
        int               exp_dup;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] k, input logic l, input logic h);
        int n;
        n = 0;
        @(negedge aclk);
        s_valid = 1'b1; s_key = k; s_last = l; s_hit = h;
        #1;
        while (!s_ready && n < 200) begin
            @(negedge aclk); #1; n++;
        end
        if (!s_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: key %0h never accepted, got ready 0 expected 1", k);
        end
        @(posedge aclk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_stat(input int base, input string tag);
        int n;
        n = 0;
        while (pulses == base && n < 100) begin
            @(negedge aclk); n++;
        end
        if (pulses == base) begin
            n_checks++; n_fail++;
            $display("FAIL %s.stat_timeout: got no stat_valid expected one pulse", tag);
        end
        repeat (4) @(negedge aclk);
    endtask

    task automatic run_burst(input vec_t v, input string tag);
        int ob, pb;
        ob = outq.size();
        pb = pulses;
        for (int i = 0; i < v.n_in; i++) send(v.in_key[i], (i == v.n_in - 1), v.in_hit[i]);
        wait_stat(pb, tag);
        check({tag, ".n_out"}, outq.size() - ob, v.n_out);
        for (int i = 0; i < v.n_out; i++) begin
            if (ob + i < outq.size())
                check({tag, ".out"}, outq[ob + i], {v.out_key[i], v.out_last[i], v.out_hit[i]});
        end
        check({tag, ".stat_distinct"}, cap_dist, v.exp_dist);
        check({tag, ".stat_dup"}, cap_dup, v.exp_dup);
        check({tag, ".pulses"}, pulses - pb, 1);
    endtask

    initial begin
        int ob, pb;
        vec_t v;

        vecs[0] = '{4, {32'hD0, 32'hC0, 32'hB0, 32'hA0}, 4'b0010,
                    3, {32'h0, 32'hD0, 32'hC0, 32'hA0}, 4'b0100, 4'b0000, 3, 1};
        vecs[1] = '{2, {32'h0, 32'h0, 32'hB1, 32'hA1}, 4'b0010,
                    1, {32'h0, 32'h0, 32'h0, 32'hA1}, 4'b0001, 4'b0000, 1, 1};
        vecs[2] = '{2, {32'h0, 32'h0, 32'h59, 32'h58}, 4'b0011,
                    1, {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0001, 4'b0001, 0, 2};
        vecs[3] = '{1, {32'h0, 32'h0, 32'h0, 32'hE0}, 4'b0000,
                    1, {32'h0, 32'h0, 32'h0, 32'hE0}, 4'b0001, 4'b0000, 1, 0};
        vecs[4] = '{4, {32'h14, 32'h13, 32'h12, 32'h11}, 4'b0000,
                    4, {32'h14, 32'h13, 32'h12, 32'h11}, 4'b1000, 4'b0000, 4, 0};

        // Reset state
        repeat (3) @(negedge aclk);
        #1;
        check("rst.m_valid", m_valid, 0);
        check("rst.s_ready", s_ready, 0);
        check("rst.stat_valid", stat_valid, 0);
        check("rst.stat_distinct", stat_distinct, 0);
        check("rst.stat_dup", stat_dup, 0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Directed bursts with the sink always ready
        for (int c = 0; c < 5; c++) run_burst(vecs[c], $sformatf("vec%0d", c));

        // Back-pressure: sink stalls for 10 cycles during a 4-key burst
        @(negedge aclk);
        m_ready = 1'b0;
        ob = outq.size();
        pb = pulses;
        fork
            begin
                send(32'h50, 1'b0, 1'b0);
                send(32'h51, 1'b0, 1'b0);
                send(32'h52, 1'b0, 1'b0);
                send(32'h53, 1'b1, 1'b0);
            end
            begin
                repeat (10) @(negedge aclk);
                #1;
                check("bp.s_ready_low", s_ready, 0);
                check("bp.m_valid_held", m_valid, 1);
                check("bp.m_key_held", m_key, 32'h50);
                @(negedge aclk);
                m_ready = 1'b1;
            end
        join
        wait_stat(pb, "bp");
        check("bp.n_out", outq.size() - ob, 4);
        check("bp.out0", outq[ob + 0], {32'h50, 1'b0, 1'b0});
        check("bp.out1", outq[ob + 1], {32'h51, 1'b0, 1'b0});
        check("bp.out2", outq[ob + 2], {32'h52, 1'b0, 1'b0});
        check("bp.out3", outq[ob + 3], {32'h53, 1'b1, 1'b0});
        check("bp.stat_distinct", cap_dist, 4);

        // Clear while stalled in FLUSH with a held key
        @(negedge aclk);
        m_ready = 1'b0;
        ob = outq.size();
        pb = pulses;
        send(32'hA2, 1'b0, 1'b0);
        send(32'hB2, 1'b1, 1'b0);
        @(negedge aclk);
        clear = 1'b1; s_valid = 1'b1; s_key = 32'h7A; s_last = 1'b1; s_hit = 1'b0;
        #1;
        check("clr.s_ready", s_ready, 0);
        @(negedge aclk);
        clear = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        repeat (10) @(negedge aclk);
        check("clr.n_out", outq.size() - ob, 1);
        if (outq.size() > ob) check("clr.out0", outq[ob], {32'hA2, 1'b0, 1'b0});
        check("clr.no_stat", pulses - pb, 0);
        check("clr.stat_kept", stat_distinct, 4);
        v = vecs[3];
        v.in_key[0] = 32'hA3;
        v.out_key[0] = 32'hA3;
        run_burst(v, "clr_next");

        // Reset mid-burst with a key held in O
        @(negedge aclk);
        m_ready = 1'b0;
        ob = outq.size();
        send(32'h61, 1'b0, 1'b0);
        send(32'h62, 1'b0, 1'b0);
        @(negedge aclk);
        #1;
        check("mid.m_valid_before", m_valid, 1);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("mid.m_valid", m_valid, 0);
        check("mid.s_ready", s_ready, 0);
        check("mid.stat_distinct", stat_distinct, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(negedge aclk);
        check("mid.n_out", outq.size() - ob, 0);
        run_burst(vecs[3], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/distinct_filter.md
DISTINCT_FILTER -- requirements
Module: distinct_filter

Interface
REQ-001 Parameter CNT_BITS, default 32, sets the width of the per-burst distinct and duplicate counters.
REQ-002 aclk  input  1  single clock; all logic on the rising edge.
REQ-003 aresetn  input  1  asynchronous, active-low reset.
REQ-004 s_meta  metaIntf.s  ext_t  input stream of {key, last, hit} tuples produced by distinct_top.
REQ-005 m_meta  metaIntf.m  ext_t  output stream of distinct keys only; hit always driven 0 except on the empty-burst marker.
REQ-006 clear  input  1  synchronous flush of held key, counters and FSM; does not affect the output register.
REQ-007 stat_distinct  output  CNT_BITS  distinct-key count of the last completed burst.
REQ-008 stat_dup  output  CNT_BITS  duplicate (hit) count of the last completed burst.
REQ-009 stat_valid  output  1  one-cycle pulse when stat_distinct/stat_dup update.

Function
REQ-010 Storage: one output register O {ov, key, last, hit} driving m_meta, and one hold register H {hv, hk}.
REQ-011 FSM states RUN and FLUSH; reset and clear enter RUN.
REQ-012 RUN: s_meta.ready = !ov || m_meta.ready; FLUSH: s_meta.ready = 0.
REQ-013 m_meta.valid = ov; m_meta.data = O; O is cleared (ov=0) on m_meta handshake unless reloaded in the same cycle.
REQ-014 Accept hit=0,last=0: if hv, load O <= {hk, last=0, hit=0}; H <= {1, key}; distinct counter +1.
REQ-015 Accept hit=1,last=0: tuple dropped; duplicate counter +1; H and O untouched.
REQ-016 Accept hit=0,last=1: if hv, load O <= {hk,0,0}; H <= {1, key}; distinct counter +1; go FLUSH.
REQ-017 Accept hit=1,last=1: duplicate counter +1; tuple dropped; go FLUSH.
REQ-018 FLUSH, when !ov || m_meta.ready: if hv, load O <= {hk, last=1, hit=0}; else load empty-burst marker O <= {key=0, last=1, hit=1}; hv <= 0; return to RUN.
REQ-019 On the FLUSH load cycle: stat_distinct/stat_dup <= current counters (including the last tuple), stat_valid=1 next cycle for exactly one cycle, counters reset to 0.
REQ-020 Counters saturate at all-ones; no wrap.
REQ-021 Latency: a distinct key appears on m_meta one cycle after the next distinct key or the burst's last tuple is accepted; FLUSH costs at least one cycle of s_meta.ready=0.
REQ-022 Output order equals input order of non-hit tuples; exactly one last=1 output per input last=1.
REQ-023 Back-pressure: O is never overwritten while ov=1 and m_meta.ready=0; s_meta.valid while ready=0 leaves all state unchanged.
REQ-024 clear: hv <= 0, counters <= 0, state <= RUN, stat_* unchanged, s_meta.ready=0 in the clear cycle; a tuple presented that cycle is not accepted.
REQ-025 clear asserted in FLUSH aborts the flush; no last output and no stat_valid for that burst.

Reset
REQ-026 On aresetn=0: ov=0, hv=0, state RUN, counters 0, stat_distinct=0, stat_dup=0, stat_valid=0, m_meta.valid=0, s_meta.ready=0 while reset asserted.
REQ-027 Reset mid-burst discards H, O and counters with no output emitted; the first accepted tuple after release starts a new burst.

Verification
REQ-028 Keys A,B(hit),C,D(last), m_meta.ready=1 -> outputs A(l0),C(l0),D(l1); stat_distinct=3, stat_dup=1, one stat_valid pulse.
REQ-029 Keys A,B(hit,last) -> outputs A(l1) only; stat_distinct=1, stat_dup=1.
REQ-030 Burst X(hit),Y(hit,last) -> single marker {key 0, last 1, hit 1}; stat_distinct=0, stat_dup=2.
REQ-031 m_meta.ready=0 for 10 cycles during 4-key burst -> s_meta.ready drops once O full; no output lost or duplicated; order preserved.
REQ-032 clear asserted while in FLUSH with hv=1 -> no last output, no stat_valid; next burst A(last) -> A(l1), stat_distinct=1.
REQ-033 aresetn pulsed low after 2 accepted distinct keys -> m_meta.valid=0 immediately; post-release burst E(last) -> E(l1), stat_distinct=1.
